// File: rtl/ctrl_seq.sv
// Control sequencer for the 16-bit basic computer: SC/halt state plus combinational strobe decode.
// Optional interrupt cycle (R flag detect and R-cycle) is built only when CTRL_INTR_EN is defined.
module ctrl_seq #(
  parameter int SC_W = 3
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            D0,
  input  logic            D1,
  input  logic            D2,
  input  logic            D3,
  input  logic            D4,
  input  logic            D5,
  input  logic            D6,
  input  logic            D7,
  input  logic            I,
  input  logic            B0,
  input  logic            B1,
  input  logic            B2,
  input  logic            B3,
  input  logic            B4,
  input  logic            B5,
  input  logic            B6,
  input  logic            B7,
  input  logic            B8,
  input  logic            B9,
  input  logic            B10,
  input  logic            B11,
  input  logic            DR_ZERO,
  input  logic [15:0]     AC_out,
  input  logic            E_in,
  input  logic            IEN_out,
  input  logic            R_out,
  input  logic            FGI,
  input  logic            FGO,
  output logic            AR_load,
  output logic            PC_load,
  output logic            DR_load,
  output logic            AC_load,
  output logic            IR_load,
  output logic            TR_load,
  output logic            OUTR_load,
  output logic            AR_reset,
  output logic            PC_reset,
  output logic            DR_reset,
  output logic            AC_reset,
  output logic            TR_reset,
  output logic            AR_inc,
  output logic            PC_inc,
  output logic            DR_inc,
  output logic            AC_inc,
  output logic            TR_inc,
  output logic            IEN_set,
  output logic            IEN_reset,
  output logic            R_load,
  output logic            R_reset,
  output logic            M_read,
  output logic            M_write,
  output logic [2:0]      BUS_sel,
  output logic [2:0]      ALU_ops,
  output logic [SC_W-1:0] sc,
  output logic            halted
);

  localparam logic [SC_W-1:0] T0 = SC_W'(0);
  localparam logic [SC_W-1:0] T1 = SC_W'(1);
  localparam logic [SC_W-1:0] T2 = SC_W'(2);
  localparam logic [SC_W-1:0] T3 = SC_W'(3);
  localparam logic [SC_W-1:0] T4 = SC_W'(4);
  localparam logic [SC_W-1:0] T5 = SC_W'(5);
  localparam logic [SC_W-1:0] T6 = SC_W'(6);

  logic [11:0]     b;
  logic [SC_W-1:0] sc_q, sc_d;
  logic            halted_q, halted_d;
  logic            clr, hlt;
  logic            intr_cycle, intr_req;

  assign b = {B11, B10, B9, B8, B7, B6, B5, B4, B3, B2, B1, B0};

`ifdef CTRL_INTR_EN
  assign intr_cycle = R_out;
  assign intr_req   = IEN_out & (FGI | FGO);
`else
  logic unused_intr;
  assign unused_intr = R_out ^ IEN_out;
  assign intr_cycle  = 1'b0;
  assign intr_req    = 1'b0;
`endif

  // These strobes exist for datapath completeness but no microoperation uses them.
  assign DR_reset = 1'b0;
  assign TR_reset = 1'b0;
  assign TR_inc   = 1'b0;

  always_comb begin
    AR_load   = 1'b0;
    PC_load   = 1'b0;
    DR_load   = 1'b0;
    AC_load   = 1'b0;
    IR_load   = 1'b0;
    TR_load   = 1'b0;
    OUTR_load = 1'b0;
    AR_reset  = 1'b0;
    PC_reset  = 1'b0;
    AC_reset  = 1'b0;
    AR_inc    = 1'b0;
    PC_inc    = 1'b0;
    DR_inc    = 1'b0;
    AC_inc    = 1'b0;
    IEN_set   = 1'b0;
    IEN_reset = 1'b0;
    R_load    = 1'b0;
    R_reset   = 1'b0;
    M_read    = 1'b0;
    M_write   = 1'b0;
    BUS_sel   = 3'd0;
    ALU_ops   = 3'd0;
    clr       = 1'b0;
    hlt       = 1'b0;
    if (!halted_q) begin
      if (sc_q > T6) begin
        clr = 1'b1;
      end else if (sc_q <= T2) begin
        if (intr_cycle) begin
          case (sc_q)
            T0:      begin AR_reset = 1'b1; BUS_sel = 3'd2; TR_load = 1'b1; end
            T1:      begin BUS_sel = 3'd6; M_write = 1'b1; PC_reset = 1'b1; end
            default: begin PC_inc = 1'b1; IEN_reset = 1'b1; R_reset = 1'b1; clr = 1'b1; end
          endcase
        end else begin
          case (sc_q)
            T0:      begin BUS_sel = 3'd2; AR_load = 1'b1; end
            T1:      begin M_read = 1'b1; BUS_sel = 3'd7; IR_load = 1'b1; PC_inc = 1'b1; end
            default: begin BUS_sel = 3'd5; AR_load = 1'b1; end
          endcase
        end
      end else begin
        R_load = intr_req;
        case (sc_q)
          T3: begin
            if (!D7) begin
              if (I) begin M_read = 1'b1; BUS_sel = 3'd7; AR_load = 1'b1; end
            end else if (!I) begin
              clr = 1'b1;
              casez (b)
                12'b1???_????_????: AC_reset = 1'b1;
                12'b01??_????_????: ALU_ops = E_in ? 3'd7 : 3'd0;
                12'b001?_????_????: begin ALU_ops = 3'd4; AC_load = 1'b1; end
                12'b0001_????_????: ALU_ops = 3'd7;
                12'b0000_1???_????: begin ALU_ops = 3'd5; AC_load = 1'b1; end
                12'b0000_01??_????: begin ALU_ops = 3'd6; AC_load = 1'b1; end
                12'b0000_001?_????: AC_inc = 1'b1;
                12'b0000_0001_????: PC_inc = ~AC_out[15];
                12'b0000_0000_1???: PC_inc = AC_out[15];
                12'b0000_0000_01??: PC_inc = (AC_out == 16'd0);
                12'b0000_0000_001?: PC_inc = ~E_in;
                12'b0000_0000_0001: hlt = 1'b1;
                default: ;
              endcase
            end else begin
              clr = 1'b1;
              casez (b[11:6])
                6'b01_????: begin BUS_sel = 3'd4; OUTR_load = 1'b1; end
                6'b00_1???: PC_inc = FGI;
                6'b00_01??: PC_inc = FGO;
                6'b00_001?: IEN_set = 1'b1;
                6'b00_0001: IEN_reset = 1'b1;
                default: ;
              endcase
            end
          end
          T4: begin
            if (D0 | D1 | D2 | D6) begin
              M_read = 1'b1; BUS_sel = 3'd7; DR_load = 1'b1;
            end else if (D3) begin
              BUS_sel = 3'd4; M_write = 1'b1; clr = 1'b1;
            end else if (D4) begin
              BUS_sel = 3'd1; PC_load = 1'b1; clr = 1'b1;
            end else if (D5) begin
              BUS_sel = 3'd2; M_write = 1'b1; AR_inc = 1'b1;
            end
          end
          T5: begin
            if (D0) begin
              ALU_ops = 3'd1; AC_load = 1'b1; clr = 1'b1;
            end else if (D1) begin
              ALU_ops = 3'd2; AC_load = 1'b1; clr = 1'b1;
            end else if (D2) begin
              ALU_ops = 3'd3; AC_load = 1'b1; clr = 1'b1;
            end else if (D5) begin
              BUS_sel = 3'd1; PC_load = 1'b1; clr = 1'b1;
            end else if (D6) begin
              DR_inc = 1'b1;
            end
          end
          T6: begin
            if (D6) begin
              BUS_sel = 3'd3; M_write = 1'b1; PC_inc = DR_ZERO; clr = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sc_d     = halted_q ? sc_q : (clr ? '0 : sc_q + SC_W'(1));
  assign halted_d = halted_q | hlt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sc_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      sc_q     <= sc_d;
      halted_q <= halted_d;
    end
  end

  assign sc     = sc_q;
  assign halted = halted_q;

endmodule
